// File: rtl/ysyx_22041211_ex_mem_reg.sv
// EX/MEM pipeline register: 2-entry skid buffer that also resolves branch
// outcome, branch target and writeback data at capture time.
module ysyx_22041211_ex_mem_reg #(
    parameter int unsigned DATA_LEN = 32
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [DATA_LEN-1:0] alu_result_i,
    input  logic                alu_zero_i,
    input  logic                alu_less_i,
    input  logic [DATA_LEN-1:0] pc_i,
    input  logic [DATA_LEN-1:0] imm_i,
    input  logic [2:0]          br_type_i,
    input  logic                jalr_i,
    input  logic [4:0]          rd_i,
    input  logic                reg_wen_i,
    input  logic                flush_i,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_LEN-1:0] wb_data_o,
    output logic                br_taken_o,
    output logic [DATA_LEN-1:0] br_target_o,
    output logic [4:0]          rd_o,
    output logic                reg_wen_o
);

    localparam int unsigned RD_W = 5;

    // Encoding makes bit 0 the main valid flag and bit 1 the skid valid flag.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_t;

    state_t state_q;
    state_t state_d;

    logic                accept_c;
    logic                drain_c;
    logic                load_main_in_c;
    logic                load_main_skid_c;
    logic                load_skid_c;

    logic                new_taken_c;
    logic [DATA_LEN-1:0] new_target_c;
    logic [DATA_LEN-1:0] new_wb_c;

    logic [DATA_LEN-1:0] main_wb_q;
    logic                main_taken_q;
    logic [DATA_LEN-1:0] main_target_q;
    logic [RD_W-1:0]     main_rd_q;
    logic                main_wen_q;

    logic [DATA_LEN-1:0] skid_wb_q;
    logic                skid_taken_q;
    logic [DATA_LEN-1:0] skid_target_q;
    logic [RD_W-1:0]     skid_rd_q;
    logic                skid_wen_q;

    // Branch resolution of the incoming instruction.
    always_comb begin
        new_taken_c  = 1'b0;
        new_target_c = pc_i + imm_i;
        new_wb_c     = alu_result_i;
        case (br_type_i)
            3'd1:        new_taken_c = alu_zero_i;
            3'd2:        new_taken_c = ~alu_zero_i;
            3'd3, 3'd5:  new_taken_c = alu_less_i;
            3'd4, 3'd6:  new_taken_c = ~alu_less_i;
            3'd7: begin
                new_taken_c = 1'b1;
                new_wb_c    = pc_i + DATA_LEN'(4);
                if (jalr_i) begin
                    new_target_c = {alu_result_i[DATA_LEN-1:1], 1'b0};
                end
            end
            default:     new_taken_c = 1'b0;
        endcase
    end

    assign in_ready  = ~state_q[1];
    assign out_valid = state_q[0];
    assign accept_c  = in_valid & ~state_q[1] & ~flush_i;
    assign drain_c   = state_q[0] & out_ready;

    // Main takes new data when empty or when its occupant leaves this cycle;
    // otherwise an accepted instruction parks in skid.
    assign load_main_in_c   = accept_c & (~state_q[0] | drain_c);
    assign load_main_skid_c = state_q[1] & drain_c;
    assign load_skid_c      = accept_c & state_q[0] & ~drain_c;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = EMPTY;
        end else begin
            case (state_q)
                EMPTY: if (accept_c) state_d = ONE;
                ONE: begin
                    if (accept_c && !drain_c) begin
                        state_d = TWO;
                    end else if (!accept_c && drain_c) begin
                        state_d = EMPTY;
                    end
                end
                TWO:     if (drain_c) state_d = ONE;
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_wb_q     <= '0;
            main_taken_q  <= 1'b0;
            main_target_q <= '0;
            main_rd_q     <= '0;
            main_wen_q    <= 1'b0;
        end else if (load_main_in_c) begin
            main_wb_q     <= new_wb_c;
            main_taken_q  <= new_taken_c;
            main_target_q <= new_target_c;
            main_rd_q     <= rd_i;
            main_wen_q    <= reg_wen_i;
        end else if (load_main_skid_c) begin
            main_wb_q     <= skid_wb_q;
            main_taken_q  <= skid_taken_q;
            main_target_q <= skid_target_q;
            main_rd_q     <= skid_rd_q;
            main_wen_q    <= skid_wen_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            skid_wb_q     <= '0;
            skid_taken_q  <= 1'b0;
            skid_target_q <= '0;
            skid_rd_q     <= '0;
            skid_wen_q    <= 1'b0;
        end else if (load_skid_c) begin
            skid_wb_q     <= new_wb_c;
            skid_taken_q  <= new_taken_c;
            skid_target_q <= new_target_c;
            skid_rd_q     <= rd_i;
            skid_wen_q    <= reg_wen_i;
        end
    end

    assign wb_data_o   = main_wb_q;
    assign br_target_o = main_target_q;
    assign rd_o        = main_rd_q;
    assign br_taken_o  = main_taken_q & state_q[0];
    assign reg_wen_o   = main_wen_q & state_q[0];

endmodule

// File: tb/tb_ysyx_22041211_ex_mem_reg.sv
// Directed bench for the EX/MEM skid register: vector table plus
// back-pressure, flush and async reset sequences.
module tb_ysyx_22041211_ex_mem_reg;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result_i;
    logic        alu_zero_i;
    logic        alu_less_i;
    logic [31:0] pc_i;
    logic [31:0] imm_i;
    logic [2:0]  br_type_i;
    logic        jalr_i;
    logic [4:0]  rd_i;
    logic        reg_wen_i;
    logic        flush_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] wb_data_o;
    logic        br_taken_o;
    logic [31:0] br_target_o;
    logic [4:0]  rd_o;
    logic        reg_wen_o;

    int n_total = 0;
    int n_pass  = 0;

    ysyx_22041211_ex_mem_reg #(.DATA_LEN(32)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .alu_result_i (alu_result_i),
        .alu_zero_i   (alu_zero_i),
        .alu_less_i   (alu_less_i),
        .pc_i         (pc_i),
        .imm_i        (imm_i),
        .br_type_i    (br_type_i),
        .jalr_i       (jalr_i),
        .rd_i         (rd_i),
        .reg_wen_i    (reg_wen_i),
        .flush_i      (flush_i),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .wb_data_o    (wb_data_o),
        .br_taken_o   (br_taken_o),
        .br_target_o  (br_target_o),
        .rd_o         (rd_o),
        .reg_wen_o    (reg_wen_o)
    );

    typedef struct {
        logic [2:0]  br;
        logic        zero;
        logic        less;
        logic        jalr;
        logic [31:0] alu;
        logic [31:0] pc;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        wen;
        logic [31:0] exp_wb;
        logic        exp_taken;
        logic [31:0] exp_tgt;
    } vec_t;

    vec_t vecs[10];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input vec_t v);
        in_valid     = 1'b1;
        br_type_i    = v.br;
        alu_zero_i   = v.zero;
        alu_less_i   = v.less;
        jalr_i       = v.jalr;
        alu_result_i = v.alu;
        pc_i         = v.pc;
        imm_i        = v.imm;
        rd_i         = v.rd;
        reg_wen_i    = v.wen;
    endtask

    // Plain ALU-type instruction tagged by rd and alu result.
    task automatic drive_tag(input logic [4:0] rd, input logic [31:0] alu);
        vec_t v;
        v = '{3'd0, 1'b0, 1'b0, 1'b0, alu, 32'h0, 32'h0, rd, 1'b1, alu, 1'b0, 32'h0};
        drive(v);
    endtask

    task automatic chk_out(input string name, input logic [4:0] rd, input logic [31:0] wb);
        chk({name, ".valid"}, 32'(out_valid), 32'd1);
        chk({name, ".rd"},    32'(rd_o),      32'(rd));
        chk({name, ".wb"},    wb_data_o,      wb);
    endtask

    task automatic chk_all_zero(input string name);
        chk({name, ".valid"},  32'(out_valid),  32'd0);
        chk({name, ".ready"},  32'(in_ready),   32'd1);
        chk({name, ".wb"},     wb_data_o,       32'd0);
        chk({name, ".taken"},  32'(br_taken_o), 32'd0);
        chk({name, ".target"}, br_target_o,     32'd0);
        chk({name, ".rd"},     32'(rd_o),       32'd0);
        chk({name, ".wen"},    32'(reg_wen_o),  32'd0);
    endtask

    initial begin
        vecs[0] = '{3'd1, 1'b1, 1'b0, 1'b0, 32'h0, 32'h80000000, 32'h10, 5'd1, 1'b0, 32'h0, 1'b1, 32'h80000010};
        vecs[1] = '{3'd7, 1'b0, 1'b0, 1'b1, 32'h80001235, 32'h80000100, 32'h0, 5'd1, 1'b1, 32'h80000104, 1'b1, 32'h80001234};
        vecs[2] = '{3'd2, 1'b1, 1'b0, 1'b0, 32'h5, 32'h100, 32'hFFFFFFF0, 5'd2, 1'b0, 32'h5, 1'b0, 32'hF0};
        vecs[3] = '{3'd3, 1'b0, 1'b1, 1'b0, 32'h0, 32'h0, 32'h8, 5'd3, 1'b0, 32'h0, 1'b1, 32'h8};
        vecs[4] = '{3'd4, 1'b0, 1'b1, 1'b0, 32'h1, 32'hFFFFFFFC, 32'h8, 5'd4, 1'b0, 32'h1, 1'b0, 32'h4};
        vecs[5] = '{3'd5, 1'b1, 1'b0, 1'b0, 32'h2, 32'h40, 32'h4, 5'd5, 1'b0, 32'h2, 1'b0, 32'h44};
        vecs[6] = '{3'd6, 1'b0, 1'b0, 1'b0, 32'h3, 32'h40, 32'hFFFFFFFC, 5'd6, 1'b0, 32'h3, 1'b1, 32'h3C};
        vecs[7] = '{3'd0, 1'b1, 1'b1, 1'b0, 32'hDEADBEEF, 32'h200, 32'h20, 5'd7, 1'b1, 32'hDEADBEEF, 1'b0, 32'h220};
        vecs[8] = '{3'd7, 1'b0, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFC, 32'h20, 5'd31, 1'b1, 32'h0, 1'b1, 32'h1C};
        vecs[9] = '{3'd1, 1'b0, 1'b0, 1'b1, 32'h77777777, 32'h1000, 32'h10, 5'd9, 1'b1, 32'h77777777, 1'b0, 32'h1010};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1; flush_i = 1'b0;
        alu_result_i = '0; alu_zero_i = 1'b0; alu_less_i = 1'b0; pc_i = '0; imm_i = '0;
        br_type_i = '0; jalr_i = 1'b0; rd_i = '0; reg_wen_i = 1'b0;
        #12;
        chk_all_zero("reset");
        rst_n = 1'b1;
        step();

        // Continuous streaming: each vector appears the cycle after it is driven.
        for (int i = 0; i < 10; i++) begin
            drive(vecs[i]);
            step();
            chk($sformatf("vec%0d.valid", i),  32'(out_valid),  32'd1);
            chk($sformatf("vec%0d.ready", i),  32'(in_ready),   32'd1);
            chk($sformatf("vec%0d.wb", i),     wb_data_o,       vecs[i].exp_wb);
            chk($sformatf("vec%0d.taken", i),  32'(br_taken_o), 32'(vecs[i].exp_taken));
            chk($sformatf("vec%0d.target", i), br_target_o,     vecs[i].exp_tgt);
            chk($sformatf("vec%0d.rd", i),     32'(rd_o),       32'(vecs[i].rd));
            chk($sformatf("vec%0d.wen", i),    32'(reg_wen_o),  32'(vecs[i].wen));
        end
        in_valid = 1'b0;
        step();
        chk("drain.valid", 32'(out_valid),  32'd0);
        chk("drain.taken", 32'(br_taken_o), 32'd0);
        chk("drain.wen",   32'(reg_wen_o),  32'd0);

        // Back-pressure: A, B fill both entries, C must wait.
        out_ready = 1'b0;
        drive_tag(5'd10, 32'hA);
        step();
        chk_out("bp.a0", 5'd10, 32'hA);
        chk("bp.a0.ready", 32'(in_ready), 32'd1);
        drive_tag(5'd11, 32'hB);
        step();
        chk_out("bp.a1", 5'd10, 32'hA);
        chk("bp.a1.ready", 32'(in_ready), 32'd0);
        drive_tag(5'd12, 32'hC);
        step();
        chk_out("bp.hold", 5'd10, 32'hA);
        chk("bp.hold.ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        step();
        chk_out("bp.b", 5'd11, 32'hB);
        chk("bp.b.ready", 32'(in_ready), 32'd1);
        step();
        chk_out("bp.c", 5'd12, 32'hC);
        in_valid = 1'b0;
        step();
        chk("bp.end.valid", 32'(out_valid), 32'd0);

        // Flush while full with a pending input.
        out_ready = 1'b0;
        drive_tag(5'd13, 32'hD);
        step();
        drive_tag(5'd14, 32'hE);
        step();
        chk("fl.full.ready", 32'(in_ready), 32'd0);
        drive_tag(5'd15, 32'hF);
        flush_i = 1'b1;
        step();
        chk("fl.valid", 32'(out_valid), 32'd0);
        chk("fl.ready", 32'(in_ready),  32'd1);
        chk("fl.wen",   32'(reg_wen_o), 32'd0);
        flush_i = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        step();
        chk("fl.after.valid", 32'(out_valid), 32'd0);

        // Flush in ONE wins over a simultaneous accept and drain.
        drive_tag(5'd16, 32'h10);
        step();
        chk_out("fl1.pre", 5'd16, 32'h10);
        drive_tag(5'd17, 32'h11);
        flush_i = 1'b1;
        step();
        chk("fl1.valid", 32'(out_valid), 32'd0);
        flush_i = 1'b0;
        in_valid = 1'b0;
        step();
        chk("fl1.after.valid", 32'(out_valid), 32'd0);

        // Async reset between edges while full.
        out_ready = 1'b0;
        drive(vecs[1]);
        step();
        drive(vecs[7]);
        step();
        in_valid = 1'b0;
        chk("ar.full.ready", 32'(in_ready), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk_all_zero("ar");
        #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        step();
        chk("ar.after.valid", 32'(out_valid), 32'd0);
        chk("ar.after.ready", 32'(in_ready),  32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
